// File: rtl/enc8b10b_lanes.sv
// Multi-lane 8b/10b encoder (IEEE 802.3 cl.36) with running-disparity chaining across lanes
// and a registered valid/ready output stage feeding the PISO serialiser.
module enc8b10b_lanes #(
  parameter int LANES   = 2,
  parameter bit RD_INIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*LANES-1:0]    din,
  input  logic [LANES-1:0]      kin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [10*LANES-1:0]   dout,
  output logic [LANES-1:0]      code_err,
  output logic                  rd_out
);

  typedef struct packed {
    logic [9:0] code;  // bit 0 = a (first on the wire)
    logic       rd;    // running disparity after this character
    logic       err;   // illegal K byte replaced by K28.5
  } enc_t;

  // RD- column of the 5b/6b table, written abcdei with a as MSB.
  function automatic logic [5:0] code6(input logic [4:0] x);
    case (x)
      5'd0:  code6 = 6'b100111;  5'd1:  code6 = 6'b011101;
      5'd2:  code6 = 6'b101101;  5'd3:  code6 = 6'b110001;
      5'd4:  code6 = 6'b110101;  5'd5:  code6 = 6'b101001;
      5'd6:  code6 = 6'b011001;  5'd7:  code6 = 6'b111000;
      5'd8:  code6 = 6'b111001;  5'd9:  code6 = 6'b100101;
      5'd10: code6 = 6'b010101;  5'd11: code6 = 6'b110100;
      5'd12: code6 = 6'b001101;  5'd13: code6 = 6'b101100;
      5'd14: code6 = 6'b011100;  5'd15: code6 = 6'b010111;
      5'd16: code6 = 6'b011011;  5'd17: code6 = 6'b100011;
      5'd18: code6 = 6'b010011;  5'd19: code6 = 6'b110010;
      5'd20: code6 = 6'b001011;  5'd21: code6 = 6'b101010;
      5'd22: code6 = 6'b011010;  5'd23: code6 = 6'b111010;
      5'd24: code6 = 6'b110011;  5'd25: code6 = 6'b100110;
      5'd26: code6 = 6'b010110;  5'd27: code6 = 6'b110110;
      5'd28: code6 = 6'b001110;  5'd29: code6 = 6'b101110;
      5'd30: code6 = 6'b011110;  default: code6 = 6'b101011;
    endcase
  endfunction

  // 3b/4b tables indexed by the RD at the sub-block input (RD- column), fghj with f as MSB.
  function automatic logic [3:0] code4d(input logic [2:0] y);
    case (y)
      3'd0: code4d = 4'b1011;  3'd1: code4d = 4'b1001;
      3'd2: code4d = 4'b0101;  3'd3: code4d = 4'b1100;
      3'd4: code4d = 4'b1101;  3'd5: code4d = 4'b1010;
      3'd6: code4d = 4'b0110;  default: code4d = 4'b1110;
    endcase
  endfunction

  function automatic logic [3:0] code4k(input logic [2:0] y);
    case (y)
      3'd0: code4k = 4'b1011;  3'd1: code4k = 4'b0110;
      3'd2: code4k = 4'b1010;  3'd3: code4k = 4'b1100;
      3'd4: code4k = 4'b1101;  3'd5: code4k = 4'b0101;
      3'd6: code4k = 4'b1001;  default: code4k = 4'b0111;
    endcase
  endfunction

  function automatic enc_t enc_byte(input logic [7:0] b, input logic k, input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic       legal_k, unbal6, rd6, a7, unbal4, inv4;
    logic [5:0] c6;
    logic [3:0] c4;
    logic [9:0] w;
    enc_t       r;
    x = b[4:0];
    y = b[7:5];
    legal_k = (x == 5'd28) ||
              (y == 3'd7 && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30));
    r.err = k && !legal_k;
    if (r.err) begin
      x = 5'd28;
      y = 3'd5;
    end
    c6 = (k && x == 5'd28) ? 6'b001111 : code6(x);
    unbal6 = ($countones(c6) != 3);
    // D.07 is balanced yet still has distinct RD-/RD+ forms.
    if (rd_in && (unbal6 || c6 == 6'b111000)) c6 = ~c6;
    rd6 = rd_in ^ unbal6;
    a7 = (y == 3'd7) && (rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                             : (x == 5'd17 || x == 5'd18 || x == 5'd20));
    if (k)       c4 = code4k(y);
    else if (a7) c4 = 4'b0111;
    else         c4 = code4d(y);
    unbal4 = ($countones(c4) != 2);
    // Every K 4b code, and balanced D.x.3, flips column on RD+.
    inv4 = k || unbal4 || (c4 == 4'b1100);
    if (rd6 && inv4) c4 = ~c4;
    r.rd = rd6 ^ unbal4;
    w = {c6, c4};
    for (int j = 0; j < 10; j++) r.code[j] = w[9-j];
    return r;
  endfunction

  logic                rd_q;
  logic                rd_next;
  logic [10*LANES-1:0] enc_code;
  logic [LANES-1:0]    enc_err;
  logic                accept;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    logic rd_c;
    enc_t e;
    enc_code = '0;
    enc_err  = '0;
    rd_c     = rd_q;
    for (int i = 0; i < LANES; i++) begin
      e = enc_byte(din[8*i +: 8], kin[i], rd_c);
      enc_code[10*i +: 10] = e.code;
      enc_err[i]           = e.err;
      rd_c                 = e.rd;
    end
    rd_next = rd_c;
  end

  assign in_ready = !reset && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign rd_out   = rd_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      code_err  <= '0;
      rd_q      <= RD_INIT;
    end else if (accept) begin
      out_valid <= 1'b1;
      dout      <= enc_code;
      code_err  <= enc_err;
      rd_q      <= rd_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
